// File: rtl/avr_adc_scanner.sv
// rtl/avr_adc_scanner.sv - AVR ADC frame decoder, round-robin channel scanner and tagged sample FIFO.
// Optional per-entry push timestamp enabled by defining AVR_TIMESTAMP_EN.
module avr_adc_scanner #(
   parameter int SAMPLE_W = 10,
   parameter int NUM_CH   = 16,
   parameter int DEPTH    = 16,
   parameter int TS_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ready,
   input  logic                     spi_ss,
   input  logic                     spi_done,
   input  logic [7:0]               spi_dout,
   output logic [3:0]               spi_channel,
   input  logic                     scan_en,
   input  logic [NUM_CH-1:0]        channel_mask,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SAMPLE_W-1:0]      out_sample,
   output logic [3:0]               out_channel,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   input  logic                     clr_overflow
`ifdef AVR_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]          out_ts
`endif
);

   localparam int AW = $clog2(DEPTH);
`ifdef AVR_TIMESTAMP_EN
   localparam int EW = SAMPLE_W + 4 + TS_W;
`else
   localparam int EW = SAMPLE_W + 4;
`endif

   typedef enum logic {PH_LO, PH_HI} phase_t;

   logic                rst_int;
   phase_t              phase, phase_nxt;
   logic                frame_done;
   logic [7:0]          lo_byte;
   logic [SAMPLE_W-1:0] frame_sample;
   logic [3:0]          frame_channel;
   logic [EW-1:0]       entry;
   logic [EW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic                full, pop, do_push, drop;
   logic [3:0]          ptr, ptr_nxt;
   logic                ptr_hit, mask_any;
   logic                byte_unused;

   assign rst_int     = rst | ~ready;
   assign byte_unused = ^spi_dout;

   // Byte phase: spi_ss high aborts any partial frame, even on a done cycle.
   always_ff @(posedge clk) begin
      if (rst_int) phase <= PH_LO;
      else         phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt  = phase;
      frame_done = 1'b0;
      if (spi_ss) begin
         phase_nxt = PH_LO;
      end else if (spi_done) begin
         if (phase == PH_LO) begin
            phase_nxt = PH_HI;
         end else begin
            phase_nxt  = PH_LO;
            frame_done = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!spi_ss && spi_done && phase == PH_LO) lo_byte <= spi_dout;
   end

   generate
      if (SAMPLE_W == 8) begin : g_w8
         assign frame_sample = lo_byte;
      end else begin : g_wide
         assign frame_sample = {spi_dout[SAMPLE_W-9:0], lo_byte};
      end
   endgenerate
   assign frame_channel = spi_dout[7:4];

`ifdef AVR_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   always_ff @(posedge clk) begin
      if (rst_int) ts_cnt <= '0;
      else         ts_cnt <= ts_cnt + 1'b1;
   end
   assign entry  = {ts_cnt, frame_channel, frame_sample};
   assign out_ts = mem[rd_ptr][EW-1:SAMPLE_W+4];
`else
   assign entry = {frame_channel, frame_sample};
`endif

   // A pop on the same edge frees the slot, so a full FIFO still accepts that push.
   assign out_valid = (fifo_count != '0);
   assign full      = (fifo_count == (AW+1)'(DEPTH));
   assign pop       = out_valid & out_ready;
   assign do_push   = frame_done & (~full | pop);
   assign drop      = frame_done & full & ~pop;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk) begin
      if (rst_int) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (!do_push && pop) fifo_count <= fifo_count - 1'b1;
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   assign out_sample  = mem[rd_ptr][SAMPLE_W-1:0];
   assign out_channel = mem[rd_ptr][SAMPLE_W+3:SAMPLE_W];

   // Circular search starting just above ptr; a lone set bit maps back onto ptr.
   assign mask_any = |channel_mask;
   assign ptr_hit  = |(channel_mask & (NUM_CH'(1) << ptr));

   always_comb begin
      int  idx;
      logic found;
      ptr_nxt = ptr;
      found   = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(ptr) + i) % NUM_CH;
         if (!found && channel_mask[idx]) begin
            ptr_nxt = idx[3:0];
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_int) begin
         ptr <= '0;
      end else if (scan_en && mask_any) begin
         if ((frame_done && frame_channel == ptr) || !ptr_hit) ptr <= ptr_nxt;
      end
   end

   assign spi_channel = (!rst_int && scan_en && mask_any) ? ptr : 4'hF;

endmodule
